op_rsl_wb_arbiter: RTL and testbench
====================================

# op_rsl_wb_arbiter

Round-robin write-back arbiter that shares one result write-back port between the four operand-result (op_rsl) issue channels. Each channel offers a result with valid/ready. The block grants at most one channel per cycle and registers the winner into a single-entry output stage. It also keeps per-channel saturating grant counters for fairness checks. It sits between the op_rsl ready/valid outputs of the issue stage and the register-file write-back port.

## Interface
- DW, 64, result data width
- TW, 6, destination register tag width
- CW, 16, grant counter width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- io_flush  in  1  synchronous pipeline flush
- io_is_op_rsl_N_valid  in  1  channel N result valid, N=0..3
- io_is_op_rsl_N_ready  out  1  channel N result accepted, N=0..3
- io_is_op_rsl_N_data  in  DW  channel N result data
- io_is_op_rsl_N_tag  in  TW  channel N destination tag
- io_wb_valid  out  1  write-back entry valid
- io_wb_ready  in  1  write-back consumer ready
- io_wb_data  out  DW  registered result data
- io_wb_tag  out  TW  registered destination tag
- io_wb_src  out  2  index of the channel that produced the entry
- io_grant_cnt_N  out  CW  accepted transfers from channel N, saturating, N=0..3

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Output stage: a single register holding {wb_valid, wb_data, wb_tag, wb_src}.
- Load enable: load_en = !io_flush && (!io_wb_valid || io_wb_ready). Throughput is one result per cycle when the consumer stays ready.
- Grant selection (combinational):
  - Scan channels ptr, ptr+1, ptr+2, ptr+3 (mod 4) and pick the first with valid=1.
  - io_is_op_rsl_k_ready = load_en && (k is the winner). All other readies are 0.
  - Ready does not depend on the channel's own valid, except through winner selection.
- Transfer: valid && ready on channel k. On the next edge:
  - the output register loads data/tag, src=k, wb_valid=1;
  - ptr becomes (k+1) mod 4;
  - grant_cnt_k increments by 1, saturating at 2^CW-1.
- Output draining: if io_wb_valid && io_wb_ready and no transfer occurs, wb_valid clears to 0.
- Output holding: if io_wb_valid && !io_wb_ready, the output register holds stable and all input readies are 0.
- Flush: io_flush=1 clears wb_valid on the next edge and forces all readies to 0. wb_data, wb_tag, wb_src, ptr and the counters are unchanged.
- No valid channels: readies are still 0, because there is no winner. ptr is unchanged.
- Reset values: wb_valid=0, wb_data=0, wb_tag=0, wb_src=0, ptr=0, all grant_cnt=0. While reset_n=0, all io_is_op_rsl_N_ready=0.

## Timing
- Latency: 1 cycle from input handshake to io_wb_valid=1 with the matching data.
- Back-to-back: with io_wb_ready held 1, accepts one transfer every cycle with no bubble.
- Same-cycle dequeue: a dequeue and a new load in the same cycle replace the entry. wb_valid stays 1.
- Fairness: a continuously valid channel is granted within 4 transfers.
- Flush and transfer together: flush wins. No input handshake occurs and the counters do not change.
- Mid-operation reset: asserting reset_n low clears state immediately and asynchronously, regardless of the clock. The pending output entry is lost.
- Deassertion: the first grant after reset_n rises is evaluated on the first clock edge with reset_n=1. ptr=0, so channel 0 has priority.
- Counter saturation: at 2^CW-1, further transfers leave the counter unchanged. Arbitration is unaffected.

## Test plan
- Single channel: reset, then channel 2 valid with data=0x1234, tag=5, io_wb_ready=1. Expect ready_2=1 in the same cycle; next cycle wb_valid=1, data=0x1234, tag=5, src=2; grant_cnt_2=1.
- All four valid continuously, io_wb_ready=1, 8 cycles. Expect grant order 0,1,2,3,0,1,2,3. Each counter equals 2. wb_valid stays 1 from cycle 2 on.
- Backpressure: channels 0 and 1 valid, io_wb_ready=0 after the first load. Expect all readies 0 and the output held stable with src=0. After releasing io_wb_ready=1, expect channel 1 granted next.
- Flush: output holds an entry, all channels valid, io_flush=1 for one cycle. Expect readies 0 and wb_valid=0 next cycle, with counters and ptr unchanged. Arbitration resumes from the unchanged ptr afterwards.
- Reset mid-stream: assert reset_n=0 between edges while wb_valid=1. Expect wb_valid=0, all counters 0 and all readies 0 immediately. After release, channel 0 wins first when all channels are valid.
- Saturation: preload grant_cnt_3 to 0xFFFE via repeated transfers from channel 3 alone. Two further grants leave it at 0xFFFF and the grants themselves still occur.

Source files
------------

// File: rtl/op_rsl_wb_arbiter_if.sv
// op_rsl_wb_arbiter_if
//   Bundles the four op_rsl result channels, the flush input, the write-back
//   output stage and the per-channel grant counters of op_rsl_wb_arbiter.
//   slave  : arbiter view (channel valid/data/tag, flush, wb_ready in;
//            channel ready, wb_*, grant counters out)
//   master : issue-stage / consumer / bench view (directions reversed)
interface op_rsl_wb_arbiter_if #(
  parameter int DW = 64,
  parameter int TW = 6,
  parameter int CW = 16
);
  logic          io_flush;

  logic          io_is_op_rsl_0_valid;
  logic          io_is_op_rsl_1_valid;
  logic          io_is_op_rsl_2_valid;
  logic          io_is_op_rsl_3_valid;
  logic          io_is_op_rsl_0_ready;
  logic          io_is_op_rsl_1_ready;
  logic          io_is_op_rsl_2_ready;
  logic          io_is_op_rsl_3_ready;
  logic [DW-1:0] io_is_op_rsl_0_data;
  logic [DW-1:0] io_is_op_rsl_1_data;
  logic [DW-1:0] io_is_op_rsl_2_data;
  logic [DW-1:0] io_is_op_rsl_3_data;
  logic [TW-1:0] io_is_op_rsl_0_tag;
  logic [TW-1:0] io_is_op_rsl_1_tag;
  logic [TW-1:0] io_is_op_rsl_2_tag;
  logic [TW-1:0] io_is_op_rsl_3_tag;

  logic          io_wb_valid;
  logic          io_wb_ready;
  logic [DW-1:0] io_wb_data;
  logic [TW-1:0] io_wb_tag;
  logic [1:0]    io_wb_src;

  logic [CW-1:0] io_grant_cnt_0;
  logic [CW-1:0] io_grant_cnt_1;
  logic [CW-1:0] io_grant_cnt_2;
  logic [CW-1:0] io_grant_cnt_3;

  modport slave (
    input  io_flush,
    input  io_is_op_rsl_0_valid, io_is_op_rsl_1_valid, io_is_op_rsl_2_valid, io_is_op_rsl_3_valid,
    output io_is_op_rsl_0_ready, io_is_op_rsl_1_ready, io_is_op_rsl_2_ready, io_is_op_rsl_3_ready,
    input  io_is_op_rsl_0_data, io_is_op_rsl_1_data, io_is_op_rsl_2_data, io_is_op_rsl_3_data,
    input  io_is_op_rsl_0_tag, io_is_op_rsl_1_tag, io_is_op_rsl_2_tag, io_is_op_rsl_3_tag,
    output io_wb_valid,
    input  io_wb_ready,
    output io_wb_data, io_wb_tag, io_wb_src,
    output io_grant_cnt_0, io_grant_cnt_1, io_grant_cnt_2, io_grant_cnt_3
  );

  modport master (
    output io_flush,
    output io_is_op_rsl_0_valid, io_is_op_rsl_1_valid, io_is_op_rsl_2_valid, io_is_op_rsl_3_valid,
    input  io_is_op_rsl_0_ready, io_is_op_rsl_1_ready, io_is_op_rsl_2_ready, io_is_op_rsl_3_ready,
    output io_is_op_rsl_0_data, io_is_op_rsl_1_data, io_is_op_rsl_2_data, io_is_op_rsl_3_data,
    output io_is_op_rsl_0_tag, io_is_op_rsl_1_tag, io_is_op_rsl_2_tag, io_is_op_rsl_3_tag,
    input  io_wb_valid,
    output io_wb_ready,
    input  io_wb_data, io_wb_tag, io_wb_src,
    input  io_grant_cnt_0, io_grant_cnt_1, io_grant_cnt_2, io_grant_cnt_3
  );
endinterface

// File: rtl/op_rsl_wb_arbiter.sv
// op_rsl_wb_arbiter
//   Round-robin arbiter sharing one register-file write-back port between the
//   four op_rsl issue channels. At most one channel is granted per cycle; the
//   winner is registered into a single-entry output stage. Per-channel
//   saturating grant counters record accepted transfers.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : channel handshakes, flush, write-back stage, grant counters
module op_rsl_wb_arbiter #(
  parameter int DW = 64,
  parameter int TW = 6,
  parameter int CW = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  op_rsl_wb_arbiter_if.slave bus
);

  logic [3:0]    valid;
  logic [DW-1:0] in_data [4];
  logic [TW-1:0] in_tag  [4];

  assign valid      = {bus.io_is_op_rsl_3_valid, bus.io_is_op_rsl_2_valid,
                       bus.io_is_op_rsl_1_valid, bus.io_is_op_rsl_0_valid};
  assign in_data[0] = bus.io_is_op_rsl_0_data;
  assign in_data[1] = bus.io_is_op_rsl_1_data;
  assign in_data[2] = bus.io_is_op_rsl_2_data;
  assign in_data[3] = bus.io_is_op_rsl_3_data;
  assign in_tag[0]  = bus.io_is_op_rsl_0_tag;
  assign in_tag[1]  = bus.io_is_op_rsl_1_tag;
  assign in_tag[2]  = bus.io_is_op_rsl_2_tag;
  assign in_tag[3]  = bus.io_is_op_rsl_3_tag;

  logic          wb_valid_q, wb_valid_d;
  logic [DW-1:0] wb_data_q,  wb_data_d;
  logic [TW-1:0] wb_tag_q,   wb_tag_d;
  logic [1:0]    wb_src_q,   wb_src_d;
  logic [1:0]    ptr_q,      ptr_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  logic          load_en;
  logic          found;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic          xfer;
  logic [3:0]    ready;

  always_comb begin
    load_en = !bus.io_flush && (!wb_valid_q || bus.io_wb_ready);

    // First valid channel scanning upward from ptr, wrapping mod 4.
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    // reset_n gating keeps every ready low while reset is held, even though
    // the cleared output stage would otherwise look loadable.
    xfer  = reset_n && load_en && found;
    ready = '0;
    if (xfer) ready[win] = 1'b1;

    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_tag_d   = wb_tag_q;
    wb_src_d   = wb_src_q;
    ptr_d      = ptr_q;
    for (int unsigned k = 0; k < 4; k++) cnt_d[k] = cnt_q[k];

    if (bus.io_flush) begin
      wb_valid_d = 1'b0;
    end else if (xfer) begin
      wb_valid_d = 1'b1;
      wb_data_d  = in_data[win];
      wb_tag_d   = in_tag[win];
      wb_src_d   = win;
      ptr_d      = win + 2'd1;
      if (cnt_q[win] != '1) cnt_d[win] = cnt_q[win] + CW'(1);
    end else if (wb_valid_q && bus.io_wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
      wb_src_q   <= '0;
      ptr_q      <= '0;
      for (int unsigned k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_tag_q   <= wb_tag_d;
      wb_src_q   <= wb_src_d;
      ptr_q      <= ptr_d;
      for (int unsigned k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign bus.io_is_op_rsl_0_ready = ready[0];
  assign bus.io_is_op_rsl_1_ready = ready[1];
  assign bus.io_is_op_rsl_2_ready = ready[2];
  assign bus.io_is_op_rsl_3_ready = ready[3];
  assign bus.io_wb_valid          = wb_valid_q;
  assign bus.io_wb_data           = wb_data_q;
  assign bus.io_wb_tag            = wb_tag_q;
  assign bus.io_wb_src            = wb_src_q;
  assign bus.io_grant_cnt_0       = cnt_q[0];
  assign bus.io_grant_cnt_1       = cnt_q[1];
  assign bus.io_grant_cnt_2       = cnt_q[2];
  assign bus.io_grant_cnt_3       = cnt_q[3];

endmodule

// File: tb/tb_op_rsl_wb_arbiter.sv
// tb_op_rsl_wb_arbiter
//   Directed bench for op_rsl_wb_arbiter: a vector table for round-robin,
//   backpressure, drain and flush behaviour, plus hand-written sequences for
//   single-channel latency, mid-stream reset and counter saturation.
module tb_op_rsl_wb_arbiter;
  localparam int DW = 64;
  localparam int TW = 6;
  localparam int CW = 16;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  op_rsl_wb_arbiter_if #(.DW(DW), .TW(TW), .CW(CW)) bus ();

  op_rsl_wb_arbiter #(.DW(DW), .TW(TW), .CW(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] valid;
    logic       wbr;
    logic       flush;
    logic [3:0] exp_ready;
    logic       exp_wbv;
    logic [1:0] exp_src;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  function automatic logic [DW-1:0] mk_data(input int k, input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(i) << 8) | 64'(k);
  endfunction

  function automatic logic [TW-1:0] mk_tag(input int k, input int i);
    return TW'((k << 4) | (i & 15));
  endfunction

  function automatic logic [3:0] rdy();
    return {bus.io_is_op_rsl_3_ready, bus.io_is_op_rsl_2_ready,
            bus.io_is_op_rsl_1_ready, bus.io_is_op_rsl_0_ready};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_cnts(input string name, input int c0, input int c1, input int c2, input int c3);
    chk({name, "_cnt0"}, 64'(bus.io_grant_cnt_0), 64'(c0));
    chk({name, "_cnt1"}, 64'(bus.io_grant_cnt_1), 64'(c1));
    chk({name, "_cnt2"}, 64'(bus.io_grant_cnt_2), 64'(c2));
    chk({name, "_cnt3"}, 64'(bus.io_grant_cnt_3), 64'(c3));
  endtask

  task automatic drive(input logic [3:0] v, input logic wbr, input logic fl, input int i);
    bus.io_is_op_rsl_0_valid = v[0];
    bus.io_is_op_rsl_1_valid = v[1];
    bus.io_is_op_rsl_2_valid = v[2];
    bus.io_is_op_rsl_3_valid = v[3];
    bus.io_is_op_rsl_0_data  = mk_data(0, i);
    bus.io_is_op_rsl_1_data  = mk_data(1, i);
    bus.io_is_op_rsl_2_data  = mk_data(2, i);
    bus.io_is_op_rsl_3_data  = mk_data(3, i);
    bus.io_is_op_rsl_0_tag   = mk_tag(0, i);
    bus.io_is_op_rsl_1_tag   = mk_tag(1, i);
    bus.io_is_op_rsl_2_tag   = mk_tag(2, i);
    bus.io_is_op_rsl_3_tag   = mk_tag(3, i);
    bus.io_wb_ready          = wbr;
    bus.io_flush             = fl;
  endtask

  // Holds reset with all channels valid (readies must stay low), then
  // releases it away from a clock edge and returns at posedge+1.
  task automatic do_reset(input string name);
    reset_n = 1'b0;
    drive(4'hF, 1'b1, 1'b0, 0);
    #2;
    chk({name, "_ready"}, 64'(rdy()), 64'h0);
    chk({name, "_wbv"}, 64'(bus.io_wb_valid), 64'h0);
    chk({name, "_src"}, 64'(bus.io_wb_src), 64'h0);
    chk({name, "_data"}, bus.io_wb_data, 64'h0);
    chk_cnts(name, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk({name, "_ready_hold"}, 64'(rdy()), 64'h0);
    #1;
    reset_n = 1'b1;
    drive(4'h0, 1'b1, 1'b0, 0);
    @(posedge clock);
    #1;
  endtask

  logic [DW-1:0] exp_data;
  logic [TW-1:0] exp_tag;

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 0);

    // valid, wb_ready, flush, expected ready, expected wb_valid/src after edge
    vec[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
    vec[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
    vec[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2};
    vec[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3};
    vec[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
    vec[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
    vec[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2};
    vec[7]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3};
    vec[8]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3}; // drain, no winner
    vec[9]  = '{4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
    vec[10] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0}; // backpressure
    vec[11] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    vec[12] = '{4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1}; // ch1 next
    vec[13] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0}; // wrap 2,3,0
    vec[14] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0}; // flush
    vec[15] = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1}; // resumes at ptr=1
    vec[16] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3};
    vec[17] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3}; // hold
    vec[18] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3}; // drain

    #2;
    do_reset("rst0");

    // Single channel: ready in the same cycle, entry one cycle later.
    drive(4'b0100, 1'b1, 1'b0, 0);
    bus.io_is_op_rsl_2_data = 64'h1234;
    bus.io_is_op_rsl_2_tag  = 6'd5;
    #3;
    chk("single_ready", 64'(rdy()), 64'b0100);
    @(posedge clock);
    #1;
    chk("single_wbv", 64'(bus.io_wb_valid), 64'h1);
    chk("single_data", bus.io_wb_data, 64'h1234);
    chk("single_tag", 64'(bus.io_wb_tag), 64'd5);
    chk("single_src", 64'(bus.io_wb_src), 64'd2);
    chk_cnts("single", 0, 0, 1, 0);

    do_reset("rst1");

    exp_data = '0;
    exp_tag  = '0;
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].valid, vec[i].wbr, vec[i].flush, i);
      #3;
      chk($sformatf("v%0d_ready", i), 64'(rdy()), 64'(vec[i].exp_ready));
      @(posedge clock);
      #1;
      if (vec[i].exp_ready != 4'b0000) begin
        exp_data = mk_data(int'(vec[i].exp_src), i);
        exp_tag  = mk_tag(int'(vec[i].exp_src), i);
      end
      chk($sformatf("v%0d_wbv", i), 64'(bus.io_wb_valid), 64'(vec[i].exp_wbv));
      chk($sformatf("v%0d_src", i), 64'(bus.io_wb_src), 64'(vec[i].exp_src));
      chk($sformatf("v%0d_data", i), bus.io_wb_data, exp_data);
      chk($sformatf("v%0d_tag", i), 64'(bus.io_wb_tag), 64'(exp_tag));
      if (i == 7)  chk_cnts("rr8", 2, 2, 2, 2);
      if (i == 14) chk_cnts("flush", 4, 3, 2, 2);
    end
    chk_cnts("table_end", 4, 4, 2, 3);

    // Mid-stream reset: load one entry, then drop reset between edges.
    drive(4'b1111, 1'b1, 1'b0, 40);
    @(posedge clock);
    #1;
    chk("mid_pre_wbv", 64'(bus.io_wb_valid), 64'h1);
    chk("mid_pre_src", 64'(bus.io_wb_src), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_wbv", 64'(bus.io_wb_valid), 64'h0);
    chk("mid_ready", 64'(rdy()), 64'h0);
    chk_cnts("mid", 0, 0, 0, 0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    drive(4'b1111, 1'b1, 1'b0, 41);
    #1;
    chk("post_rst_ready", 64'(rdy()), 64'b0001);
    @(posedge clock);
    #1;
    chk("post_rst_wbv", 64'(bus.io_wb_valid), 64'h1);
    chk("post_rst_src", 64'(bus.io_wb_src), 64'd0);
    chk("post_rst_data", bus.io_wb_data, mk_data(0, 41));
    chk_cnts("post_rst", 1, 0, 0, 0);

    // Saturation: channel 3 alone until its counter reaches 0xFFFE.
    drive(4'b1000, 1'b1, 1'b0, 50);
    repeat (65534) @(posedge clock);
    #1;
    chk("sat_pre_cnt3", 64'(bus.io_grant_cnt_3), 64'hFFFE);
    for (int j = 0; j < 2; j++) begin
      drive(4'b1000, 1'b1, 1'b0, 60 + j);
      #3;
      chk($sformatf("sat%0d_ready", j), 64'(rdy()), 64'b1000);
      @(posedge clock);
      #1;
      chk($sformatf("sat%0d_cnt3", j), 64'(bus.io_grant_cnt_3), 64'hFFFF);
      chk($sformatf("sat%0d_wbv", j), 64'(bus.io_wb_valid), 64'h1);
      chk($sformatf("sat%0d_data", j), bus.io_wb_data, mk_data(3, 60 + j));
    end
    drive(4'b1001, 1'b1, 1'b0, 70);
    #3;
    chk("sat_after_ready", 64'(rdy()), 64'b0001);
    @(posedge clock);
    #1;
    chk("sat_after_src", 64'(bus.io_wb_src), 64'd0);
    chk_cnts("sat_after", 2, 0, 0, 65535);

    drive(4'b0000, 1'b1, 1'b0, 0);
    @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
